// File: rtl/param_data_mem.sv
// Parametrised single-port data memory with valid/ready requests,
// byte write enables, out-of-range flagging and a post-reset clear.
module param_data_mem #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 12,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [DWIDTH/8-1:0]   req_be,
  input  logic [AWIDTH-1:0]     req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DWIDTH-1:0]     rsp_rdata,
  output logic                  err_oob,
  output logic                  init_busy
);

  localparam int BW = DWIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LAST_W  = (AWIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE_WAIT,
    READY
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH:0]   clr_cnt;
  logic [AWIDTH:0]   clr_nxt;
  logic              clr_we;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              acc;
  logic              oob;
  logic              rd_hit;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     clr_idx;

  logic              v1;
  logic              o1;
  logic [DWIDTH-1:0] d1;
  logic              wr_err;

  logic              v_out;
  logic              o_out;
  logic [DWIDTH-1:0] d_out;

  assign acc     = req_valid & req_ready;
  assign oob     = {1'b0, req_addr} >= DEPTH_W;
  assign rd_hit  = acc & ~req_wen & ~oob;
  assign idx     = req_addr[IW-1:0];
  assign clr_idx = clr_cnt[IW-1:0];

  // State and clear counter; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (INIT_CLEAR != 0) ? CLEAR : IDLE_WAIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  // Next state: sweep every word once, then accept requests forever.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    clr_we    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        clr_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_W) begin
          state_nxt = READY;
        end
      end
      IDLE_WAIT: state_nxt = READY;
      READY:     state_nxt = READY;
      default:   state_nxt = READY;
    endcase
  end

  // Storage writes: clear sweep or byte-masked in-range request.
  always_ff @(posedge clk) begin
    if (!rst && clr_we) begin
      mem[clr_idx] <= '0;
    end else if (!rst && acc && req_wen && !oob) begin
      for (int i = 0; i < BW; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // First read stage and the write out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      o1     <= 1'b0;
      d1     <= '0;
      wr_err <= 1'b0;
    end else begin
      v1     <= acc & ~req_wen;
      o1     <= acc & ~req_wen & oob;
      d1     <= rd_hit ? mem[idx] : '0;
      wr_err <= acc & req_wen & oob;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2;
      logic              o2;
      logic [DWIDTH-1:0] d2;

      // Extra output register stage for the two-cycle latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          v2 <= 1'b0;
          o2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          o2 <= o1;
          d2 <= d1;
        end
      end

      assign v_out = v2;
      assign o_out = o2;
      assign d_out = d2;
    end else begin : g_lat1
      assign v_out = v1;
      assign o_out = o1;
      assign d_out = d1;
    end
  endgenerate

  assign req_ready = (state == READY);
  assign init_busy = (state == CLEAR);
  assign rsp_valid = v_out;
  assign rsp_rdata = v_out ? d_out : '0;
  assign err_oob   = wr_err | o_out;

endmodule

// File: tb/tb_param_data_mem.sv
// Scoreboard bench for param_data_mem: two configurations share a clock,
// directed stimulus pushes expectations, a negedge monitor checks them.
module tb_param_data_mem;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = 2;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int depth_of [2] = '{16, 10};
  int lat_of   [2] = '{1, 2};

  logic          rst       [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_wen   [2];
  logic [BW-1:0] req_be    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          err_oob   [2];
  logic          init_busy [2];

  exp_t q0[$];
  exp_t q1[$];
  int   eq0[$];
  int   eq1[$];

  param_data_mem #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(16),
    .RD_LAT(1), .INIT_CLEAR(1)
  ) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_be(req_be[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .err_oob(err_oob[0]), .init_busy(init_busy[0])
  );

  param_data_mem #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(10),
    .RD_LAT(2), .INIT_CLEAR(0)
  ) u1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_be(req_be[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .err_oob(err_oob[1]), .init_busy(init_busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_rd(input int k, input logic [DW-1:0] d,
                         input int due);
    exp_t e;
    e.d   = d;
    e.due = due;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_err(input int k, input int due);
    if (k == 0) eq0.push_back(due);
    else        eq1.push_back(due);
  endtask

  task automatic flush(input int k);
    if (k == 0) begin
      q0.delete();
      eq0.delete();
    end else begin
      q1.delete();
      eq1.delete();
    end
  endtask

  task automatic pop_rd(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mon(input int k);
    exp_t e;
    int   n;
    bit   ed;
    n = (k == 0) ? q0.size() : q1.size();
    e.d = '0;
    e.due = 0;
    if (n > 0) e = (k == 0) ? q0[0] : q1[0];
    if (rsp_valid[k]) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL u%0d_unexpected_rsp: got data %0h, expected none",
                 k, rsp_rdata[k]);
      end else begin
        pop_rd(k);
        chk($sformatf("u%0d_rsp_data", k), rsp_rdata[k], e.d);
        chk($sformatf("u%0d_rsp_cycle", k), cyc, e.due);
      end
    end else begin
      if (n > 0 && e.due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL u%0d_missing_rsp: got none at %0d, expected %0h",
                 k, cyc, e.d);
        pop_rd(k);
      end
      chk($sformatf("u%0d_idle_rdata", k), rsp_rdata[k], 0);
    end
    if (k == 0) ed = (eq0.size() > 0) && (eq0[0] == cyc);
    else        ed = (eq1.size() > 0) && (eq1[0] == cyc);
    if (err_oob[k] || ed) begin
      chk($sformatf("u%0d_err_oob@%0d", k, cyc), err_oob[k], ed);
      if (ed && k == 0) void'(eq0.pop_front());
      if (ed && k == 1) void'(eq1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0);
      mon(1);
    end
  end

  task automatic issue(input int k, input bit wen, input logic [BW-1:0] be,
                       input int a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_d);
    int  n;
    bit  o;
    n = 0;
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_be[k]    = be;
    req_addr[k]  = AW'(a);
    req_wdata[k] = wd;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      checks++;
      errors++;
      $display("FAIL u%0d_accept_timeout: got ready=0, expected 1", k);
    end else begin
      o = (a >= depth_of[k]);
      if (!wen) begin
        push_rd(k, o ? '0 : exp_d, cyc + lat_of[k]);
        if (o) push_err(k, cyc + lat_of[k]);
      end else if (o) begin
        push_err(k, cyc + 1);
      end
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [BW-1:0] be, input int a,
                    input logic [DW-1:0] d);
    issue(k, 1'b1, be, a, d, '0);
  endtask

  task automatic rd(input int k, input int a, input logic [DW-1:0] d);
    issue(k, 1'b0, '0, a, '0, d);
  endtask

  task automatic chk_rst(input int k);
    chk($sformatf("u%0d_rst_ready", k), req_ready[k], 0);
    chk($sformatf("u%0d_rst_rsp_valid", k), rsp_valid[k], 0);
    chk($sformatf("u%0d_rst_rdata", k), rsp_rdata[k], 0);
    chk($sformatf("u%0d_rst_err", k), err_oob[k], 0);
  endtask

  task automatic busy_len(input int k, input int exp);
    int n;
    n = 0;
    chk($sformatf("u%0d_ready_while_busy", k), req_ready[k], 0);
    while (init_busy[k] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("u%0d_busy_len", k), n, exp);
    chk($sformatf("u%0d_ready_after_clear", k), req_ready[k], 1);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_wen[k]   = 1'b0;
      req_be[k]    = '0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk_rst(0);
    chk_rst(1);
    chk("u0_busy_in_rst", init_busy[0], 1);
    chk("u1_busy_in_rst", init_busy[1], 0);

    rst[0] = 1'b0;
    busy_len(0, 16);
    for (int i = 0; i < 16; i++) rd(0, i, 16'h0000);
    wr(0, 2'b11, 5, 16'hABCD);
    wr(0, 2'b10, 5, 16'h1200);
    rd(0, 5, 16'h12CD);
    wr(0, 2'b11, 7, 16'h5555);
    rd(0, 7, 16'h5555);
    wr(0, 2'b00, 7, 16'hFFFF);
    rd(0, 7, 16'h5555);
    wr(0, 2'b01, 15, 16'h77EE);
    rd(0, 15, 16'h00EE);
    drain();

    rst[0] = 1'b1;
    flush(0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("u0_busy_mid_clear", init_busy[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_rst(0);
    rst[0] = 1'b0;
    busy_len(0, 16);
    rd(0, 5, 16'h0000);
    rd(0, 15, 16'h0000);
    drain();

    chk_rst(1);
    rst[1] = 1'b0;
    chk("u1_idle_wait_ready", req_ready[1], 0);
    chk("u1_idle_wait_busy", init_busy[1], 0);
    @(negedge clk);
    chk("u1_ready", req_ready[1], 1);
    for (int i = 0; i < 10; i++) wr(1, 2'b11, i, DW'(16'h0100 + i));
    wr(1, 2'b11, 3, 16'h0003);
    wr(1, 2'b11, 4, 16'h0004);
    rd(1, 3, 16'h0003);
    rd(1, 4, 16'h0004);
    rd(1, 3, 16'h0003);
    wr(1, 2'b11, 12, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      rd(1, i, 16'h0003);
      else if (i == 4) rd(1, i, 16'h0004);
      else             rd(1, i, DW'(16'h0100 + i));
    end
    rd(1, 12, 16'h0000);
    wr(1, 2'b11, 8, 16'h8888);
    rd(1, 8, 16'h8888);
    drain();

    rd(1, 5, 16'h0105);
    rst[1] = 1'b1;
    flush(1);
    @(negedge clk);
    chk_rst(1);
    rst[1] = 1'b0;
    chk("u1_post_rst_ready", req_ready[1], 0);
    @(negedge clk);
    chk("u1_post_rst_ready2", req_ready[1], 1);
    drain();
    rd(1, 5, 16'h0105);
    rd(1, 3, 16'h0003);
    drain();

    chk("u0_queue_empty", q0.size() + eq0.size(), 0);
    chk("u1_queue_empty", q1.size() + eq1.size(), 0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/param_data_mem.md
Name: param_data_mem

Overview:
- Parametrised successor to the single-port instruction/data memory.
- Configurable width, depth and read latency.
- Adds a valid/ready request handshake, per-byte write enables and out-of-range detection.
- Adds a hardware clear sequence after reset, replacing file preload; contents are zeroed by an internal state machine.
- Sits between the CPU load/store stage and storage; one request per cycle, single port.

Parameters:
- DWIDTH, 16, data word width in bits; must be a multiple of 8.
- AWIDTH, 12, word address width.
- DEPTH, 4096, number of words; must satisfy DEPTH <= 2**AWIDTH.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2 (2 adds an output register stage).
- INIT_CLEAR, 1, selects reset behaviour:
  - 1: zero all words after reset.
  - 0: skip clearing and keep contents.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_wen  in  1  1=write, 0=read.
- req_be  in  DWIDTH/8  byte write enables; bit i covers bits 8i+7:8i.
- req_addr  in  AWIDTH  word address.
- req_wdata  in  DWIDTH  write data.
- rsp_valid  out  1  read data valid; single-cycle pulse per read.
- rsp_rdata  out  DWIDTH  read data; 0 whenever rsp_valid=0.
- err_oob  out  1  pulse: accepted request addressed >= DEPTH.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst=1 at an edge) sets the following next cycle:
  - rsp_valid=0, rsp_rdata=0, err_oob=0, req_ready=0.
  - Read pipeline flushed; in-flight reads produce no response.
  - State=CLEAR with clr_cnt=0 if INIT_CLEAR=1; else state=IDLE_WAIT.
- States:
  - CLEAR:
    - init_busy=1, req_ready=0.
    - Each cycle writes 0 to word clr_cnt, then clr_cnt+1.
    - After writing word DEPTH-1, go to READY; total DEPTH cycles.
  - IDLE_WAIT: one cycle with init_busy=0, req_ready=0, then READY.
  - READY:
    - req_ready=1, init_busy=0.
    - Stays in READY until rst.
- rst asserted mid-CLEAR restarts clr_cnt at 0; partially cleared contents are irrelevant.
- rst held high: block stays in reset state with all outputs at reset values.
- Request acceptance: accepted on an edge where req_valid & req_ready = 1.
  - req_valid while req_ready=0 is ignored and not queued.
  - The requester must hold the request.
- Write (req_wen=1, addr < DEPTH):
  - Byte lanes with req_be[i]=1 are updated at the accepting edge.
  - Other lanes are unchanged.
  - req_be=0 is a legal no-op.
  - No response is generated.
- Read (req_wen=0, addr < DEPTH):
  - rsp_valid=1 exactly RD_LAT cycles after the accepting edge.
  - rsp_rdata is the word value after all writes accepted on earlier edges.
  - Back-to-back reads give one response per cycle, in order.
  - There is no response backpressure.
- Read after write to the same address on consecutive cycles returns the new data.
  - Write-then-read ordering must hold for RD_LAT=1 and 2.
- Out of range (addr >= DEPTH; only possible when DEPTH < 2**AWIDTH):
  - Write: dropped, memory unchanged; err_oob=1 for one cycle, the cycle after acceptance.
  - Read: rsp_valid still pulses at RD_LAT with rsp_rdata=0; err_oob=1 in the same cycle as that rsp_valid.
- Address arithmetic: clr_cnt is AWIDTH+1 bits wide so DEPTH=2**AWIDTH terminates without wrap; no address wrap on requests.
- Throughput: 1 request/cycle in READY, mixed reads and writes.

Test Plan:
- Reset/clear: DEPTH=16, INIT_CLEAR=1, pulse rst -> init_busy=1 for 16 cycles, then req_ready=1; reads of addrs 0..15 all return 0x0000.
- Byte enables: DWIDTH=16, write 0xABCD to addr 5 with be=11, then write 0x1200 with be=10, read addr 5 -> rsp_rdata=0x12CD, RD_LAT cycles after read acceptance.
- Latency and ordering:
  - RD_LAT=2: write addr 3=0x0003, addr 4=0x0004.
  - Back-to-back reads of addr 3, 4, 3 -> rsp_valid on 3 consecutive cycles, data 0x0003, 0x0004, 0x0003, first response 2 cycles after first acceptance.
- Write-then-read: write 0x5555 to addr 7, read addr 7 on the next cycle -> 0x5555 returned.
- Out of range:
  - DEPTH=10, AWIDTH=4: write addr 12 -> err_oob pulse the next cycle; words 0..9 unchanged.
  - Read addr 12 -> rsp_valid=1 with rsp_rdata=0 and err_oob=1 together.
- Reset mid-operation:
  - Assert rst at clr_cnt=7 -> clear restarts, init_busy lasts another full DEPTH cycles.
  - Assert rst with a read in flight -> no rsp_valid after reset.
  - INIT_CLEAR=0: previously written data survives reset.
